// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: flow-command encoding,
// FSM states and default vectors. Used by the decoder, the sequencer and the bench.
package pc_sequencer_pkg;

   localparam logic [2:0] CMD_INC  = 3'd0;
   localparam logic [2:0] CMD_HOLD = 3'd1;
   localparam logic [2:0] CMD_JMP  = 3'd2;
   localparam logic [2:0] CMD_BRR  = 3'd3;
   localparam logic [2:0] CMD_CALL = 3'd4;
   localparam logic [2:0] CMD_RET  = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_CALL2,
      ST_RET2,
      ST_HALT
   } state_e;

   localparam int         ADDR_W_DEF    = 8;
   localparam logic [7:0] RESET_VEC_DEF = 8'h00;
   localparam logic [7:0] IRQ_VEC_DEF   = 8'h02;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO for the PC sequencer. Push writes entry[count],
// the top of stack is entry[count-1]; only the occupancy count is reset.
module ret_stack #(
   parameter  int DEPTH = 4,
   parameter  int W     = 8,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [W-1:0]     data_i,
   output logic [W-1:0]     data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign wr_idx  = IDX_W'(count_q);
   assign top_idx = IDX_W'(count_q - CNT_W'(1));
   assign data_o  = mem_q[top_idx];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_q <= '0;
      else if (push_i && !full_o)
         count_q <= count_q + CNT_W'(1);
      else if (pop_i && !empty_o)
         count_q <= count_q - CNT_W'(1);
   end

   // NOTE: storage is deliberately not reset; entries above count are never read as valid data.
   always_ff @(posedge clk) begin
      if (push_i && !full_o)
         mem_q[wr_idx] <= data_i;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-address controller for the core's PC register: increment, hold, jump,
// relative branch, two-cycle CALL/RET/interrupt entry via a return-address stack.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter  int               ADDR_W      = ADDR_W_DEF,
   parameter  int               STACK_DEPTH = 4,
   parameter  logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(RESET_VEC_DEF),
   parameter  logic [ADDR_W-1:0] IRQ_VEC    = ADDR_W'(IRQ_VEC_DEF),
   localparam int               SP_W        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        cmd,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] target,
   input  logic [ADDR_W-1:0] offset,
   input  logic              irq_req,
   input  logic              int_en,
   output logic              irq_ack,
   output logic [ADDR_W-1:0] pc_next,
   output logic [ADDR_W-1:0] pc_cur,
   output logic [SP_W-1:0]   sp,
   output logic              stk_ovf,
   output logic              stk_unf
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] pc_inc;
   logic              irq_take, ready, do_call, do_ret;
   logic              push, pop, stk_full, stk_empty;
   logic [ADDR_W-1:0] stk_top;

   ret_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ADDR_W)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (pc_inc),
      .data_o  (stk_top),
      .full_o  (stk_full),
      .empty_o (stk_empty),
      .count_o (sp)
   );

   assign pc_inc = pc_q + ADDR_W'(1);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      pc_d     = pc_q;
      state_d  = state_q;
      tgt_d    = tgt_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      push     = 1'b0;
      pop      = 1'b0;
      irq_take = 1'b0;
      ready    = 1'b0;
      do_call  = 1'b0;
      do_ret   = 1'b0;
      case (state_q)
         ST_RUN: begin
            irq_take = irq_req && int_en;
            ready    = !irq_take;
            do_call  = irq_take || (cmd_valid && cmd == CMD_CALL);
            do_ret   = !irq_take && cmd_valid && cmd == CMD_RET;
            if (do_call) begin
               if (!stk_full) begin
                  push    = 1'b1;
                  tgt_d   = irq_take ? IRQ_VEC : target;
                  state_d = ST_CALL2;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = ST_HALT;
               end
            end else if (do_ret) begin
               if (!stk_empty) begin
                  pop     = 1'b1;
                  tgt_d   = stk_top;
                  state_d = ST_RET2;
               end else begin
                  unf_d   = 1'b1;
                  state_d = ST_HALT;
               end
            end else if (cmd_valid) begin
               // Offset is already ADDR_W wide, so modulo addition sign-extends implicitly.
               case (cmd)
                  CMD_HOLD: pc_d = pc_q;
                  CMD_JMP:  pc_d = target;
                  CMD_BRR:  pc_d = pc_inc + offset;
                  CMD_CALL, CMD_RET: pc_d = pc_q;
                  default:  pc_d = pc_inc;
               endcase
            end
         end
         ST_CALL2, ST_RET2: begin
            pc_d    = tgt_q;
            state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   assign pc_next   = rst ? RESET_VEC : pc_d;
   assign cmd_ready = ready && !rst;
   assign irq_ack   = irq_take && !rst;
   assign pc_cur    = pc_q;
   assign stk_ovf   = ovf_q;
   assign stk_unf   = unf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_VEC;
         tgt_q   <= RESET_VEC;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step queues its expected outcome and
// the queue is drained after the clock edge that produces it.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] cmd = CMD_INC;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] target = 8'h00;
   logic [7:0] offset = 8'h00;
   logic       irq_req = 1'b0;
   logic       int_en = 1'b0;
   logic       irq_ack;
   logic [7:0] pc_next;
   logic [7:0] pc_cur;
   logic [2:0] sp;
   logic       stk_ovf;
   logic       stk_unf;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [7:0] pc;
      logic [2:0] sp;
      logic       rdy;
      logic       ack;
   } exp_t;

   exp_t sb[$];

   pc_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .target    (target),
      .offset    (offset),
      .irq_req   (irq_req),
      .int_en    (int_en),
      .irq_ack   (irq_ack),
      .pc_next   (pc_next),
      .pc_cur    (pc_cur),
      .sp        (sp),
      .stk_ovf   (stk_ovf),
      .stk_unf   (stk_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic step(input string tag, input logic [2:0] c, input logic v,
                       input logic [7:0] tg, input logic [7:0] off,
                       input logic irq, input logic ie,
                       input logic [7:0] epc, input logic [2:0] esp,
                       input logic erdy, input logic eack);
      exp_t e;
      cmd = c; cmd_valid = v; target = tg; offset = off; irq_req = irq; int_en = ie;
      sb.push_back('{tag: tag, pc: epc, sp: esp, rdy: erdy, ack: eack});
      @(negedge clk);
      chk({sb[0].tag, "_ready"}, 32'(cmd_ready), 32'(sb[0].rdy));
      chk({sb[0].tag, "_ack"},   32'(irq_ack),   32'(sb[0].ack));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, "_pc"}, 32'(pc_cur), 32'(e.pc));
      chk({e.tag, "_sp"}, 32'(sp),     32'(e.sp));
   endtask

   // Asynchronous reset applied mid-cycle and checked before any clock edge.
   task automatic async_reset(input string tag);
      cmd_valid = 1'b0; irq_req = 1'b0; int_en = 1'b0;
      rst = 1'b1;
      #1;
      chk({tag, "_pc"},      32'(pc_cur),  32'h00);
      chk({tag, "_pc_next"}, 32'(pc_next), 32'h00);
      chk({tag, "_sp"},      32'(sp),      32'h0);
      chk({tag, "_ovf"},     32'(stk_ovf), 32'h0);
      chk({tag, "_unf"},     32'(stk_unf), 32'h0);
      chk({tag, "_ack"},     32'(irq_ack), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1;
      async_reset("reset0");

      step("inc1",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 1, 0);
      step("inc2",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h02, 3'd0, 1, 0);
      step("inc3",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h03, 3'd0, 1, 0);
      step("jmpff", CMD_JMP,  1, 8'hFF, 8'h00, 0, 0, 8'hFF, 3'd0, 1, 0);
      step("wrap",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 1, 0);
      step("jmp10", CMD_JMP,  1, 8'h10, 8'h00, 0, 0, 8'h10, 3'd0, 1, 0);
      step("brr_m", CMD_BRR,  1, 8'h00, 8'hFC, 0, 0, 8'h0D, 3'd0, 1, 0);
      step("jmp10b",CMD_JMP,  1, 8'h10, 8'h00, 0, 0, 8'h10, 3'd0, 1, 0);
      step("brr_p", CMD_BRR,  1, 8'h00, 8'h05, 0, 0, 8'h16, 3'd0, 1, 0);
      step("jmp40", CMD_JMP,  1, 8'h40, 8'h00, 0, 0, 8'h40, 3'd0, 1, 0);
      step("cmd7",  3'd7,     1, 8'h00, 8'h00, 0, 0, 8'h41, 3'd0, 1, 0);
      step("hold",  CMD_HOLD, 1, 8'h99, 8'h00, 0, 0, 8'h41, 3'd0, 1, 0);
      step("novld", CMD_JMP,  0, 8'h99, 8'h00, 0, 0, 8'h41, 3'd0, 1, 0);

      step("jmp20", CMD_JMP,  1, 8'h20, 8'h00, 0, 0, 8'h20, 3'd0, 1, 0);
      step("call",  CMD_CALL, 1, 8'h80, 8'h00, 0, 0, 8'h20, 3'd1, 1, 0);
      step("call2", CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h80, 3'd1, 0, 0);
      step("ret",   CMD_RET,  1, 8'h00, 8'h00, 0, 0, 8'h80, 3'd0, 1, 0);
      step("ret2",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h21, 3'd0, 0, 0);

      step("jmp30", CMD_JMP,  1, 8'h30, 8'h00, 0, 0, 8'h30, 3'd0, 1, 0);
      step("irq",   CMD_JMP,  1, 8'h55, 8'h00, 1, 1, 8'h30, 3'd1, 0, 1);
      step("irq2",  CMD_INC,  0, 8'h00, 8'h00, 1, 1, 8'h02, 3'd1, 0, 0);
      step("iret",  CMD_RET,  1, 8'h00, 8'h00, 0, 0, 8'h02, 3'd0, 1, 0);
      step("iret2", CMD_INC,  0, 8'h00, 8'h00, 0, 0, 8'h31, 3'd0, 0, 0);
      step("irqdis",CMD_JMP,  1, 8'h55, 8'h00, 1, 0, 8'h55, 3'd0, 1, 0);

      step("nc1",   CMD_CALL, 1, 8'h60, 8'h00, 0, 0, 8'h55, 3'd1, 1, 0);
      step("nc1b",  CMD_INC,  0, 8'h00, 8'h00, 0, 0, 8'h60, 3'd1, 0, 0);
      step("nc2",   CMD_CALL, 1, 8'h61, 8'h00, 0, 0, 8'h60, 3'd2, 1, 0);
      step("nc2b",  CMD_INC,  0, 8'h00, 8'h00, 0, 0, 8'h61, 3'd2, 0, 0);
      step("nc3",   CMD_CALL, 1, 8'h62, 8'h00, 0, 0, 8'h61, 3'd3, 1, 0);
      step("nc3b",  CMD_INC,  0, 8'h00, 8'h00, 0, 0, 8'h62, 3'd3, 0, 0);
      step("nc4",   CMD_CALL, 1, 8'h63, 8'h00, 0, 0, 8'h62, 3'd4, 1, 0);
      step("nc4b",  CMD_INC,  0, 8'h00, 8'h00, 0, 0, 8'h63, 3'd4, 0, 0);
      step("nc5",   CMD_CALL, 1, 8'h64, 8'h00, 0, 0, 8'h63, 3'd4, 1, 0);
      chk("ovf_set", 32'(stk_ovf), 32'h1);
      chk("unf_clr", 32'(stk_unf), 32'h0);
      step("halt_i",CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h63, 3'd4, 0, 0);
      step("halt_q",CMD_JMP,  1, 8'h10, 8'h00, 1, 1, 8'h63, 3'd4, 0, 0);
      chk("ovf_sticky", 32'(stk_ovf), 32'h1);
      async_reset("reset_halt");
      step("post_rst", CMD_INC, 1, 8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 1, 0);

      async_reset("reset1");
      step("unf_ret", CMD_RET, 1, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 1, 0);
      chk("unf_set", 32'(stk_unf), 32'h1);
      chk("ovf_clr", 32'(stk_ovf), 32'h0);
      step("unf_halt", CMD_INC, 1, 8'h00, 8'h00, 0, 0, 8'h00, 3'd0, 0, 0);
      chk("unf_sticky", 32'(stk_unf), 32'h1);

      async_reset("reset2");
      step("mc_jmp",  CMD_JMP,  1, 8'h20, 8'h00, 0, 0, 8'h20, 3'd0, 1, 0);
      step("mc_call", CMD_CALL, 1, 8'h80, 8'h00, 0, 0, 8'h20, 3'd1, 1, 0);
      async_reset("reset_call2");
      step("mc_run",  CMD_INC,  1, 8'h00, 8'h00, 0, 0, 8'h01, 3'd0, 1, 0);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller for the 8-bit program counter register of the ATmega328p-style core.
- Accepts one flow command per cycle from the decoder: increment, hold, absolute jump, relative branch, call or return. Also takes external interrupts.
- Drives the PC register's new-address input every cycle.
- Owns a small hardware return-address stack and a four-state sequencing FSM.
- Makes CALL, RET and interrupt entry multi-cycle operations, as on the target core.

Parameters:
- ADDR_W, 8: PC / address width; must match the PC register data width.
- STACK_DEPTH, 4: number of return-address stack entries (>= 2).
- RESET_VEC, 0: PC value after reset.
- IRQ_VEC, 8'h02: interrupt entry address.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd  in  3  0=INC, 1=HOLD, 2=JMP, 3=BRR, 4=CALL, 5=RET; 6 and 7 are treated as INC.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when valid && ready.
- target  in  ADDR_W  absolute address for JMP/CALL.
- offset  in  ADDR_W  signed two's-complement displacement for BRR.
- irq_req  in  1  level interrupt request.
- int_en  in  1  global interrupt enable.
- irq_ack  out  1  one-cycle pulse when an interrupt is taken.
- pc_next  out  ADDR_W  combinational next address; connects to the PC register new-address input.
- pc_cur  out  ADDR_W  internally registered current PC (mirror of the PC register).
- sp  out  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stk_ovf  out  1  sticky; CALL or interrupt attempted with a full stack.
- stk_unf  out  1  sticky; RET attempted with an empty stack.

Behaviour:
- Reset (async):
  - pc_cur=RESET_VEC, sp=0, state=RUN.
  - irq_ack=0, stk_ovf=0, stk_unf=0.
  - Stack contents are don't-care.
  - pc_next=RESET_VEC while rst is high.
- Every cycle, pc_cur <= pc_next.
- pc_next is pc_cur unless stated below.
- All address arithmetic is modulo 2^ADDR_W and wraps silently (8'hFF+1 = 8'h00).
- States: RUN, CALL2, RET2, HALT.
- cmd_ready=1 only in RUN, and only when no interrupt is being taken that cycle.
- Interrupt in RUN:
  - Taken when irq_req && int_en.
  - Takes priority over any cmd; the cmd is not accepted.
  - Behaves as a CALL with target=IRQ_VEC.
  - irq_ack=1 in that same cycle.
- RUN, valid command accepted:
  - INC: pc_next = pc_cur+1.
  - HOLD: pc_next = pc_cur.
  - JMP: pc_next = target.
  - BRR: pc_next = pc_cur + 1 + offset (offset sign-extended).
  - CALL or interrupt, stack not full: push pc_cur+1, sp+1. Latch target (or IRQ_VEC). pc_next = pc_cur. Go to CALL2.
  - CALL or interrupt, stack full: no push, stk_ovf<=1, pc_next = pc_cur, go to HALT.
  - RET, stack not empty: pop the top entry into a holding register, sp-1, pc_next = pc_cur, go to RET2.
  - RET, stack empty: stk_unf<=1, pc_next = pc_cur, go to HALT.
- RUN, no valid command: pc_next = pc_cur (hold).
- CALL2: pc_next = latched target; go to RUN. Total CALL latency is 2 cycles from acceptance to new PC.
- RET2: pc_next = popped address; go to RUN. Total RET latency is 2 cycles.
- HALT:
  - pc_next = pc_cur.
  - cmd_ready=0; interrupts ignored.
  - Left only by rst.
- Stack:
  - LIFO, indexed by sp.
  - Push writes entry[sp]; pop reads entry[sp-1].
  - Never a simultaneous push and pop (FSM guarantees it).
- Reset mid-CALL2/RET2: the operation is abandoned; state and flags as in the reset bullet.

Decomposition:
- Shared package, used by the decoder and the bench:
  - cmd encoding constants (CMD_INC…CMD_RET).
  - FSM state enum.
  - RESET_VEC and IRQ_VEC defaults.
- One natural sub-module: ret_stack.
  - Parameterised LIFO: push/pop/data_in/data_out/full/empty/count.
  - Async reset of count only.
- The FSM and next-address mux stay in pc_sequencer.

Test Plan:
- Reset then INC x3: pc_cur steps 0→1→2→3. At 8'hFF, INC gives 8'h00.
- At pc=8'h10: BRR offset=8'hFC gives pc 8'h0D. BRR offset=8'h05 gives 8'h16. JMP target=8'h40 gives 8'h40 next cycle.
- At pc=8'h20: CALL target=8'h80.
  - Required: cmd_ready=0 for 1 cycle, pc 8'h20 then 8'h80, sp=1.
  - Then RET: pc 8'h80 held 1 cycle, then 8'h21, sp=0.
- irq_req=1, int_en=1, cmd=JMP valid at pc=8'h30.
  - Required: irq_ack pulse, cmd_ready=0, JMP ignored, pc becomes 8'h02, stack top 8'h31.
  - With int_en=0: no ack, JMP taken.
- STACK_DEPTH=4: five nested CALLs.
  - Required: fifth sets stk_ovf=1, state HALT, pc frozen.
  - Further commands are ignored; rst restores pc=0 and clears flags.
- RET with sp=0 → stk_unf=1 and HALT. Assert rst during CALL2 → pc=RESET_VEC and sp=0 immediately (async).
